iic_slave_module: RTL

I2C slave (responder) that emulates a 24Cxx-style serial EEPROM on the SCL/SDA bus, giving the EEPROM master block a synthesizable on-chip counterpart for loopback and board-less bring-up. It oversamples SCL/SDA on the 20 MHz system clock and decodes START/STOP. It ACKs its device address, supports byte/page write and current-address/random/sequential read, and fronts an external 256x8 memory through a simple write-strobe / read-data port.

---
 rtl/iic_slave_module_pkg.sv | 19 +
 rtl/iic_slave_module_if.sv | 9 +
 rtl/iic_slave_module_line_sync.sv | 33 +++
 rtl/iic_slave_module.sv | 94 +++++++++
 4 files changed

// File: rtl/iic_slave_module_pkg.sv
// iic_slave_module_pkg: state codes and bus constants shared by the I2C EEPROM slave
package iic_slave_module_pkg;
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_WADDR     = 4'd3,
    ST_WADDR_ACK = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'b1010000;
  localparam int DEF_HOLD_CYC = 20;
endpackage

// File: rtl/iic_slave_module_if.sv
// iic_slave_module_if: memory port between the I2C slave and its 256x8 store
interface iic_slave_module_if;
  logic [7:0] Mem_Addr;
  logic [7:0] Mem_WrData;
  logic [7:0] Mem_RdData;
  logic Mem_WrEn;
  modport slave (output Mem_Addr, Mem_WrData, Mem_WrEn, input Mem_RdData);
  modport master (input Mem_Addr, Mem_WrData, Mem_WrEn, output Mem_RdData);
endinterface

// File: rtl/iic_slave_module_line_sync.sv
// iic_line_sync: 2-flop sync of SCL/SDA with edge, START and STOP pulses
module iic_line_sync (
  input  logic CLK,
  input  logic RSTn,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] scl_sy, sda_sy;
  logic scl_q, sda_q;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], scl_in};
      sda_sy <= {sda_sy[0], sda_in};
      scl_q <= scl_sy[1];
      sda_q <= sda_sy[1];
    end
  assign sda = sda_sy[1];
  assign scl_rise = scl_sy[1] & ~scl_q;
  assign scl_fall = ~scl_sy[1] & scl_q;
  // SCL must be steady high, so a coincident SCL edge counts as a data change
  assign start = ~sda_sy[1] & sda_q & scl_sy[1] & scl_q;
  assign stop = sda_sy[1] & ~sda_q & scl_sy[1] & scl_q;
endmodule

// File: rtl/iic_slave_module.sv
// iic_slave_module: 24Cxx-style I2C EEPROM responder fronting an external 256x8 memory
module iic_slave_module
  import iic_slave_module_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic SCL,
  inout  wire  SDA,
  iic_slave_module_if.slave mem,
  output logic Busy,
  output logic [3:0] SQ_State
);
  state_t state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, ptr, hold_cnt, nb;
  logic sda_low, pend_low, sda_s, scl_rise, scl_fall, start_p, stop_p;
  iic_line_sync u_sync (
    .CLK(CLK), .RSTn(RSTn), .scl_in(SCL), .sda_in(SDA), .sda(sda_s),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start_p), .stop(stop_p)
  );
  assign SDA = sda_low ? 1'b0 : 1'bz;
  assign nb = {shreg[6:0], sda_s};
  assign mem.Mem_Addr = ptr;
  assign SQ_State = state;
  // SDA only moves HOLD_CYC after an SCL fall; pend_low is the level queued for that moment
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state <= ST_IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      ptr <= '0;
      hold_cnt <= '0;
      sda_low <= 1'b0;
      pend_low <= 1'b0;
      Busy <= 1'b0;
      mem.Mem_WrData <= '0;
      mem.Mem_WrEn <= 1'b0;
    end else begin
      mem.Mem_WrEn <= 1'b0;
      if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 1'b1;
      if (hold_cnt == 8'd1) sda_low <= pend_low;
      if (start_p || stop_p) begin
        state <= start_p ? ST_DEV : ST_IDLE;
        bit_cnt <= '0;
        hold_cnt <= '0;
        sda_low <= 1'b0;
        Busy <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_DEV, ST_WADDR, ST_WDATA: begin
            shreg <= nb;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              if (state == ST_DEV) begin
                state <= nb[7:1] == DEV_ADDR ? ST_DEV_ACK : ST_IGNORE;
                Busy <= nb[7:1] == DEV_ADDR;
              end else if (state == ST_WADDR) begin
                ptr <= nb;
                state <= ST_WADDR_ACK;
              end else begin
                mem.Mem_WrData <= nb;
                mem.Mem_WrEn <= 1'b1;
                state <= ST_WDATA_ACK;
              end
            end
          end
          ST_DEV_ACK, ST_WADDR_ACK, ST_WDATA_ACK: begin
            bit_cnt <= '0;
            state <= state == ST_DEV_ACK ? (shreg[0] ? ST_RDATA : ST_WADDR) : ST_WDATA;
            if (state == ST_WDATA_ACK) ptr <= ptr + 1'b1;
          end
          ST_RDATA: begin
            shreg <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) state <= ST_RD_ACK;
          end
          ST_RD_ACK: begin
            bit_cnt <= '0;
            ptr <= ptr + 1'b1;
            state <= sda_s == ACK ? ST_RDATA : ST_IGNORE;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        hold_cnt <= 8'(HOLD_CYC);
        pend_low <= (state == ST_DEV_ACK || state == ST_WADDR_ACK || state == ST_WDATA_ACK) ||
                    (state == ST_RDATA && (bit_cnt == 4'd0 ? !mem.Mem_RdData[7] : !shreg[7]));
        if (state == ST_RDATA && bit_cnt == 4'd0) shreg <= mem.Mem_RdData;
      end
    end
endmodule
